// File: rtl/regfile_v_pkg.sv
// Shared types for the vector register file: write modes, lane/vector types
// and the lane-merge helper used by both the write path and the read bypass.
package regfile_v_pkg;

  localparam int DEF_WIDTH  = 24;
  localparam int DEF_LANES  = 8;
  localparam int DEF_REGNUM = 16;

  typedef enum logic [1:0] {
    WM_ELEM  = 2'd0,
    WM_VEC   = 2'd1,
    WM_MASK  = 2'd2,
    WM_BCAST = 2'd3
  } wmode_e;

  typedef logic [DEF_WIDTH-1:0] lane_t;
  typedef lane_t [DEF_LANES-1:0] vec_t;

  function automatic vec_t merge_lanes(input vec_t old_v, input vec_t new_v,
                                       input logic [DEF_LANES-1:0] en);
    vec_t res;
    for (int i = 0; i < DEF_LANES; i++) begin
      res[i] = en[i] ? new_v[i] : old_v[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_v_scoreboard.sv
// Per-register busy scoreboard: reservations set busy, writebacks clear it,
// and a writeback to the requested register frees it in the same cycle.
module regfile_v_scoreboard #(
  parameter int REGNUM  = 16,
  parameter int ZERO_R0 = 1,
  parameter int AW      = $clog2(REGNUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wa,
  input  logic              i_rsv_valid,
  input  logic [AW-1:0]     i_rsv_addr,
  input  logic [AW-1:0]     i_ra1,
  input  logic [AW-1:0]     i_ra2,
  output logic              o_rsv_ready,
  output logic              o_busy1,
  output logic              o_busy2,
  output logic [REGNUM-1:0] o_busy_vec
);

  logic [REGNUM-1:0] r_busy;
  logic [REGNUM-1:0] w_busy_nxt;
  logic              w_rsv_take;

  assign o_rsv_ready = !r_busy[i_rsv_addr] || (i_we && (i_wa == i_rsv_addr));
  assign o_busy1     = r_busy[i_ra1] && !(i_we && (i_wa == i_ra1));
  assign o_busy2     = r_busy[i_ra2] && !(i_we && (i_wa == i_ra2));
  assign o_busy_vec  = r_busy;
  assign w_rsv_take  = i_rsv_valid && o_rsv_ready &&
                       !((ZERO_R0 != 0) && (i_rsv_addr == '0));

  // Clear on writeback first so a same-edge reservation of that register wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_we) begin
      w_busy_nxt[i_wa] = 1'b0;
    end else begin
      w_busy_nxt = r_busy;
    end
    if (w_rsv_take) begin
      w_busy_nxt[i_rsv_addr] = 1'b1;
    end else begin
      w_busy_nxt[i_rsv_addr] = w_busy_nxt[i_rsv_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_vm.sv
// Vector register file with element/vector/masked/broadcast writes, write-first
// read bypass, PC scalar view and a reservation scoreboard.
module regfile_vm
  import regfile_v_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LANES   = DEF_LANES,
  parameter int REGNUM  = DEF_REGNUM,
  parameter int PC_REG  = 15,
  parameter int ZERO_R0 = 1,
  localparam int AW     = $clog2(REGNUM),
  localparam int IW     = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  wmode_e                 wmode,
  input  logic [AW-1:0]          wa,
  input  logic [IW-1:0]          widx,
  input  logic [LANES-1:0]       wmask,
  input  logic [WIDTH-1:0]       wdata_s,
  input  logic [LANES*WIDTH-1:0] wdata_v,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  input  logic [IW-1:0]          ridx1,
  input  logic [IW-1:0]          ridx2,
  input  logic [WIDTH-1:0]       PC,
  output logic [LANES*WIDTH-1:0] rd1_v,
  output logic [LANES*WIDTH-1:0] rd2_v,
  output logic [WIDTH-1:0]       rd1_s,
  output logic [WIDTH-1:0]       rd2_s,
  input  logic                   rsv_valid,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_ready,
  output logic                   busy1,
  output logic                   busy2,
  output logic [REGNUM-1:0]      busy_vec
);

  vec_t             r_mem [REGNUM];
  vec_t             w_wdata_v;
  vec_t             w_wvec;
  logic [LANES-1:0] w_wen;
  logic             w_wr_ok;

  assign w_wdata_v = wdata_v;
  assign w_wr_ok   = we && !((ZERO_R0 != 0) && (wa == '0));

  // Lane enables and per-lane write data for the selected write mode
  always_comb begin
    w_wen  = '0;
    w_wvec = w_wdata_v;
    case (wmode)
      WM_ELEM: begin
        w_wen[widx] = 1'b1;
        w_wvec      = {LANES{wdata_s}};
      end
      WM_VEC:  w_wen = '1;
      WM_MASK: w_wen = wmask;
      WM_BCAST: begin
        w_wen  = '1;
        w_wvec = {LANES{wdata_s}};
      end
      default: w_wen = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGNUM; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wa] <= merge_lanes(r_mem[wa], w_wvec, w_wen);
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [AW-1:0]    w_ra;
    logic [IW-1:0]    w_ridx;
    vec_t             w_stored;
    vec_t             w_v;
    logic [WIDTH-1:0] w_s;

    assign w_ra   = (p == 0) ? ra1 : ra2;
    assign w_ridx = (p == 0) ? ridx1 : ridx2;

    // Write-first bypass: lanes being written this cycle replace stored lanes
    always_comb begin
      if ((ZERO_R0 != 0) && (w_ra == '0)) begin
        w_stored = '0;
      end else begin
        w_stored = r_mem[w_ra];
      end
      if (w_wr_ok && (wa == w_ra)) begin
        w_v = merge_lanes(w_stored, w_wvec, w_wen);
      end else begin
        w_v = w_stored;
      end
    end

    assign w_s = (w_ra == AW'(PC_REG)) ? PC : w_v[w_ridx];
  end

  assign rd1_v = g_rd[0].w_v;
  assign rd2_v = g_rd[1].w_v;
  assign rd1_s = g_rd[0].w_s;
  assign rd2_s = g_rd[1].w_s;

  regfile_v_scoreboard #(
    .REGNUM  (REGNUM),
    .ZERO_R0 (ZERO_R0),
    .AW      (AW)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (we),
    .i_wa        (wa),
    .i_rsv_valid (rsv_valid),
    .i_rsv_addr  (rsv_addr),
    .i_ra1       (ra1),
    .i_ra2       (ra2),
    .o_rsv_ready (rsv_ready),
    .o_busy1     (busy1),
    .o_busy2     (busy2),
    .o_busy_vec  (busy_vec)
  );

endmodule
